// File: rtl/agc_stream.sv
`default_nettype none
// ============================================================================
//  Module   : agc_stream
//  Purpose  : Streaming automatic gain control for complex I/Q samples.
//             A sliding window of |I|+|Q| magnitudes gives a mean level. At
//             every window end the closed loop nudges the gain so that the
//             estimated output level (mean * gain) moves toward ref_level.
//             Each sample is scaled by the gain and saturated through a fixed
//             3-stage pipeline.
//  Ports    : clk        - rising-edge clock
//             arst       - synchronous active-high reset
//             clear      - one-cycle soft restart of window, gain and FSM
//             freeze     - hold gain (TRACK -> HOLD) while high
//             ref_level  - target mean magnitude (unsigned, DW+1)
//             tol        - lock/dead band half-width (unsigned, DW+1)
//             in_valid   - in_i/in_q carry a sample this cycle
//             in_i,in_q  - signed input sample
//             out_valid  - out_i/out_q valid (in_valid delayed 3)
//             out_i,out_q- gain-scaled, saturated sample
//             gain       - current gain register (GAIN_FRAC fractional bits)
//             avg_level  - current window mean magnitude
//             locked     - TRACK and estimate inside ref_level +/- tol
//             state      - 0 FILL, 1 TRACK, 2 HOLD
//  Revision : 1.0 - initial release
// ============================================================================
module agc_stream #(
  parameter int DW        = 16,
  parameter int LOG2_WIN  = 6,
  parameter int GW        = 16,
  parameter int GAIN_FRAC = 12,
  parameter int GAIN_INIT = 4096,
  parameter int GAIN_MIN  = 64,
  parameter int GAIN_MAX  = 65535,
  parameter int ATTACK_SH = 3,
  parameter int DECAY_SH  = 5
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 clear,
  input  logic                 freeze,
  input  logic [DW:0]          ref_level,
  input  logic [DW:0]          tol,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_i,
  input  logic signed [DW-1:0] in_q,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_i,
  output logic signed [DW-1:0] out_q,
  output logic [GW-1:0]        gain,
  output logic [DW:0]          avg_level,
  output logic                 locked,
  output logic [1:0]           state
);

  localparam int c_win = 2 ** LOG2_WIN;
  // Window sum width: one magnitude times window length, cannot overflow.
  localparam int c_sw  = DW + 1 + LOG2_WIN;
  // Full-width product of a level and a gain; also holds sample * gain.
  localparam int c_pw  = DW + 1 + GW;

  localparam logic signed [c_pw-1:0] c_sat_max = c_pw'(2 ** (DW - 1) - 1);
  localparam logic signed [c_pw-1:0] c_sat_min = c_pw'(-(2 ** (DW - 1)));
  localparam logic signed [GW+1:0]   c_gmin    = (GW + 2)'(GAIN_MIN);
  localparam logic signed [GW+1:0]   c_gmax    = (GW + 2)'(GAIN_MAX);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_TRACK = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  // Absolute value widened by one bit so the most negative input maps to
  // +2^(DW-1) without wrapping.
  function automatic logic [DW:0] f_abs(input logic [DW-1:0] x);
    logic [DW:0] xe;
    xe = {x[DW-1], x};
    return x[DW-1] ? (~xe + (DW + 1)'(1)) : xe;
  endfunction

  // Estimated output level for a given mean level and gain, kept full width.
  function automatic logic [c_pw-1:0] f_est(input logic [DW:0] lvl,
                                            input logic [GW-1:0] g);
    logic [c_pw-1:0] p;
    p = c_pw'(lvl) * c_pw'(g);
    return p >> GAIN_FRAC;
  endfunction

  function automatic logic [DW-1:0] f_sat(input logic signed [c_pw-1:0] v);
    if (v > c_sat_max) begin
      return c_sat_max[DW-1:0];
    end else if (v < c_sat_min) begin
      return c_sat_min[DW-1:0];
    end
    return v[DW-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  logic [DW:0]           r_buf [c_win];
  logic [c_sw-1:0]       r_sum;
  logic [LOG2_WIN-1:0]   r_cnt;
  logic [GW-1:0]         r_gain;
  state_t                r_state;
  state_t                w_state_nxt;

  logic [DW:0]           w_mag;
  logic [DW:0]           w_oldest;
  logic [c_sw-1:0]       w_sum_nxt;
  logic [DW:0]           w_avg_nxt;
  logic                  w_accept;
  logic                  w_win_end;
  logic                  w_gain_en;

  logic [DW+1:0]         w_hi;
  logic [DW:0]           w_lo;
  logic [c_pw-1:0]       w_est_upd;
  logic [c_pw-1:0]       w_est_cur;
  logic [GW-1:0]         w_dn;
  logic [GW-1:0]         w_up;
  logic signed [GW+1:0]  w_gcalc;
  logic [GW-1:0]         w_gain_nxt;

  logic                  r_s1_v;
  logic signed [DW-1:0]  r_s1_i;
  logic signed [DW-1:0]  r_s1_q;
  logic [GW-1:0]         r_s1_g;
  logic                  r_s2_v;
  logic signed [c_pw-1:0] r_s2_pi;
  logic signed [c_pw-1:0] r_s2_pq;
  logic                  r_out_v;
  logic signed [DW-1:0]  r_out_i;
  logic signed [DW-1:0]  r_out_q;

  logic signed [GW:0]    w_g1;
  logic signed [c_pw-1:0] w_pi;
  logic signed [c_pw-1:0] w_pq;
  logic signed [c_pw-1:0] w_si;
  logic signed [c_pw-1:0] w_sq;

  // --------------------------------------------------------------------------
  // Magnitude window
  // --------------------------------------------------------------------------
  // A sample arriving with clear is still scaled but never enters the window.
  assign w_accept  = in_valid & ~clear;
  assign w_mag     = f_abs(in_i) + f_abs(in_q);
  assign w_oldest  = r_buf[r_cnt];
  assign w_sum_nxt = r_sum + c_sw'(w_mag) - c_sw'(w_oldest);
  assign w_avg_nxt = w_sum_nxt[c_sw-1:LOG2_WIN];
  assign w_win_end = w_accept & (r_cnt == '1);
  assign avg_level = r_sum[c_sw-1:LOG2_WIN];

  always_ff @(posedge clk) begin
    if (arst || clear) begin
      for (int k = 0; k < c_win; k++) begin
        r_buf[k] <= '0;
      end
      r_sum <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_buf[r_cnt] <= w_mag;
      r_sum        <= w_sum_nxt;
      r_cnt        <= r_cnt + LOG2_WIN'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (arst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gain_en   = 1'b0;
    if (clear) begin
      w_state_nxt = S_FILL;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_win_end) begin
            w_state_nxt = freeze ? S_HOLD : S_TRACK;
          end
        end
        S_TRACK: begin
          if (w_win_end && !freeze) begin
            w_gain_en = 1'b1;
          end
          if (freeze) begin
            w_state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!freeze) begin
            w_state_nxt = S_TRACK;
          end
        end
        default: w_state_nxt = S_FILL;
      endcase
    end
  end

  assign state = r_state;

  // --------------------------------------------------------------------------
  // Gain loop
  // --------------------------------------------------------------------------
  // Band edges: upper may exceed DW+1 bits, lower floors at zero.
  assign w_hi = {1'b0, ref_level} + {1'b0, tol};
  assign w_lo = (ref_level > tol) ? (ref_level - tol) : '0;

  // The update uses the window including the sample that closes it.
  assign w_est_upd = f_est(w_avg_nxt, r_gain);
  assign w_est_cur = f_est(avg_level, r_gain);

  always_comb begin
    w_dn = r_gain >> ATTACK_SH;
    if (w_dn == '0) begin
      w_dn = GW'(1);
    end
    w_up = r_gain >> DECAY_SH;
    if (w_up == '0) begin
      w_up = GW'(1);
    end
    // Two spare bits absorb both underflow and overflow before clamping.
    w_gcalc = {2'b00, r_gain};
    if (w_est_upd > c_pw'(w_hi)) begin
      w_gcalc = {2'b00, r_gain} - {2'b00, w_dn};
    end else if (w_est_upd < c_pw'(w_lo)) begin
      w_gcalc = {2'b00, r_gain} + {2'b00, w_up};
    end
    w_gain_nxt = w_gcalc[GW-1:0];
    if (w_gcalc < c_gmin) begin
      w_gain_nxt = c_gmin[GW-1:0];
    end else if (w_gcalc > c_gmax) begin
      w_gain_nxt = c_gmax[GW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (arst || clear) begin
      r_gain <= GW'(GAIN_INIT);
    end else if (w_gain_en) begin
      r_gain <= w_gain_nxt;
    end
  end

  assign gain   = r_gain;
  assign locked = (r_state == S_TRACK) &&
                  (w_est_cur >= c_pw'(w_lo)) && (w_est_cur <= c_pw'(w_hi));

  // --------------------------------------------------------------------------
  // Data path: capture (with gain) -> multiply -> shift/saturate
  // --------------------------------------------------------------------------
  assign w_g1 = {1'b0, r_s1_g};
  assign w_pi = c_pw'(r_s1_i) * c_pw'(w_g1);
  assign w_pq = c_pw'(r_s1_q) * c_pw'(w_g1);
  assign w_si = r_s2_pi >>> GAIN_FRAC;
  assign w_sq = r_s2_pq >>> GAIN_FRAC;

  always_ff @(posedge clk) begin
    if (arst) begin
      r_s1_v  <= 1'b0;
      r_s1_i  <= '0;
      r_s1_q  <= '0;
      r_s1_g  <= '0;
      r_s2_v  <= 1'b0;
      r_s2_pi <= '0;
      r_s2_pq <= '0;
      r_out_v <= 1'b0;
      r_out_i <= '0;
      r_out_q <= '0;
    end else begin
      r_s1_v  <= in_valid;
      r_s1_i  <= in_i;
      r_s1_q  <= in_q;
      r_s1_g  <= r_gain;
      r_s2_v  <= r_s1_v;
      r_s2_pi <= w_pi;
      r_s2_pq <= w_pq;
      r_out_v <= r_s2_v;
      r_out_i <= f_sat(w_si);
      r_out_q <= f_sat(w_sq);
    end
  end

  assign out_valid = r_out_v;
  assign out_i     = r_out_i;
  assign out_q     = r_out_q;

endmodule
`default_nettype wire

// File: tb/tb_agc_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_agc_stream
//  Purpose  : Self-checking bench for agc_stream. Stimulus pushes expected
//             output samples into a scoreboard; a monitor pops and compares
//             them whenever out_valid is seen. Loop behaviour is checked
//             against hand-derived gain values and a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_agc_stream;

  logic               clk = 1'b0;
  logic               arst, clear, freeze, in_valid;
  logic [16:0]        ref_level, tol;
  logic signed [15:0] in_i, in_q;
  logic               out_valid, locked;
  logic signed [15:0] out_i, out_q;
  logic [15:0]        gain;
  logic [16:0]        avg_level;
  logic [1:0]         state;

  always #5 clk = ~clk;

  agc_stream #(
    .DW(16), .LOG2_WIN(6), .GW(16), .GAIN_FRAC(12), .GAIN_INIT(4096),
    .GAIN_MIN(64), .GAIN_MAX(65535), .ATTACK_SH(3), .DECAY_SH(5)
  ) dut (
    .clk(clk), .arst(arst), .clear(clear), .freeze(freeze),
    .ref_level(ref_level), .tol(tol), .in_valid(in_valid),
    .in_i(in_i), .in_q(in_q), .out_valid(out_valid),
    .out_i(out_i), .out_q(out_q), .gain(gain), .avg_level(avg_level),
    .locked(locked), .state(state)
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     i;
    int     q;
    longint due;
  } exp_t;
  exp_t sbq[$];

  // Behavioural model of the window and the loop
  int     mbuf[64];
  longint msum;
  int     mcnt;
  int     mstate;
  longint mgain;
  int     traj[100];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic longint band_hi();
    return longint'(ref_level) + longint'(tol);
  endfunction

  function automatic longint band_lo();
    return (ref_level > tol) ? longint'(ref_level) - longint'(tol) : 0;
  endfunction

  task automatic model_reset();
    foreach (mbuf[k]) mbuf[k] = 0;
    msum   = 0;
    mcnt   = 0;
    mstate = 0;
    mgain  = 4096;
  endtask

  // Monitor: compare each presented output against the scoreboard head
  always @(negedge clk) begin : monitor
    exp_t e;
    if (out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_unexpected: got out_valid=1 (%0d,%0d), expected none", out_i, out_q);
      end else begin
        e = sbq.pop_front();
        check("out_i", out_i, e.i);
        check("out_q", out_q, e.q);
        check("latency_cycle", cyc, e.due);
      end
    end
  end

  // One clock of stimulus; model advanced for the edge that samples it
  task automatic step(input bit v, input int i, input int q,
                      input bit clr, input bit frz);
    exp_t   e;
    longint sn, est, d, ecur;
    int     m;
    bit     we;
    in_valid = v;
    in_i     = i[15:0];
    in_q     = q[15:0];
    clear    = clr;
    freeze   = frz;
    if (v) begin
      e.i   = sat16((longint'(i) * mgain) >>> 12);
      e.q   = sat16((longint'(q) * mgain) >>> 12);
      e.due = cyc + 3;
      sbq.push_back(e);
    end
    if (clr) begin
      model_reset();
    end else begin
      we = v && (mcnt == 63);
      sn = msum;
      if (v) begin
        m          = iabs(i) + iabs(q);
        sn         = msum + m - mbuf[mcnt];
        mbuf[mcnt] = m;
        mcnt       = (mcnt + 1) % 64;
        msum       = sn;
      end
      case (mstate)
        0: if (we) mstate = frz ? 2 : 1;
        1: begin
          if (we && !frz) begin
            est = ((sn >> 6) * mgain) >> 12;
            if (est > band_hi()) begin
              d = mgain >> 3;
              if (d < 1) d = 1;
              mgain = mgain - d;
            end else if (est < band_lo()) begin
              d = mgain >> 5;
              if (d < 1) d = 1;
              mgain = mgain + d;
            end
            if (mgain < 64) mgain = 64;
            if (mgain > 65535) mgain = 65535;
          end
          if (frz) mstate = 2;
        end
        default: if (!frz) mstate = 1;
      endcase
    end
    @(posedge clk);
    #1;
    ecur = ((msum >> 6) * mgain) >> 12;
    check("gain", gain, mgain);
    check("state", state, mstate);
    check("avg_level", avg_level, msum >> 6);
    check("locked", locked,
          (mstate == 1 && ecur >= band_lo() && ecur <= band_hi()) ? 1 : 0);
  endtask

  task automatic idle(input int n, input bit frz);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, frz);
  endtask

  task automatic do_reset();
    arst     = 1'b1;
    in_valid = 1'b0;
    clear    = 1'b0;
    freeze   = 1'b0;
    in_i     = '0;
    in_q     = '0;
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
    sbq.delete();
    model_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_i", out_i, 0);
    check("rst_gain", gain, 4096);
    check("rst_state", state, 0);
    check("rst_avg", avg_level, 0);
    check("rst_locked", locked, 0);
  endtask

  initial begin : stim
    int  prev;
    bit  got_lock;
    ref_level = '0;
    tol       = '0;
    foreach (traj[k]) traj[k] = 0;
    do_reset();

    // Latency and unity gain
    step(1, 1000, -500, 0, 0);
    idle(5, 0);

    // Loop up: 1000 magnitude toward 4000
    ref_level = 17'd4000;
    tol       = 17'd100;
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < 64; k++) step(1, 1000, 0, 0, 0);
    check("fill_to_track", state, 1);
    for (int k = 0; k < 64; k++) step(1, 1000, 0, 0, 0);
    check("gain_first_window_up", gain, 4224);
    traj[0]  = gain;
    prev     = gain;
    got_lock = 0;
    for (int w = 1; w < 80 && !got_lock; w++) begin
      for (int k = 0; k < 64; k++) step(1, 1000, 0, 0, 0);
      traj[w] = gain;
      check("gain_monotonic_up", (gain >= prev) ? 1 : 0, 1);
      prev = gain;
      if (locked) got_lock = 1;
    end
    check("lock_reached", got_lock, 1);
    check("lock_gain_ge_15974", (gain >= 15974) ? 1 : 0, 1);
    check("lock_gain_le_16793", (gain <= 16793) ? 1 : 0, 1);

    // Freeze for three windows, then saturation at high gain
    prev = gain;
    for (int k = 0; k < 192; k++) step(1, 1000, 0, 0, 1);
    check("freeze_gain", gain, prev);
    check("freeze_state", state, 2);
    check("freeze_locked", locked, 0);
    step(1, 30000, -32768, 0, 1);
    step(1, 1000, -1000, 0, 1);
    idle(4, 1);
    step(0, 0, 0, 0, 0);
    check("unfreeze_state", state, 1);

    // Clear together with a valid sample
    step(1, 2000, 100, 1, 0);
    check("clear_gain", gain, 4096);
    check("clear_state", state, 0);
    idle(4, 0);

    // Loop down: 16000 magnitude toward 2000
    ref_level = 17'd2000;
    tol       = 17'd50;
    for (int k = 0; k < 128; k++) step(1, 8000, 8000, 0, 0);
    check("gain_first_window_down", gain, 3584);
    prev = gain;
    for (int w = 1; w < 30; w++) begin
      for (int k = 0; k < 64; k++) step(1, 8000, 8000, 0, 0);
      if (w < 12) check("gain_decreasing", (gain < prev) ? 1 : 0, 1);
      check("gain_floor", (gain >= 64) ? 1 : 0, 1);
      prev = gain;
    end

    // Gapped input: same trajectory as the continuous run
    ref_level = 17'd4000;
    tol       = 17'd100;
    step(0, 0, 0, 1, 0);
    for (int w = 0; w < 5; w++) begin
      for (int k = 0; k < 128; k++) step((k % 2) == 0, 1000, 0, 0, 0);
      if (w == 0) check("gap_fill_to_track", state, 1);
      else check("gap_gain_traj", gain, traj[w-1]);
    end

    // Reset mid-stream drops in-flight samples
    idle(4, 0);
    step(1, 100, 100, 0, 0);
    step(1, 200, 200, 0, 0);
    do_reset();
    idle(6, 0);
    check("scoreboard_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
